uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if - serial line input, enable and received-byte outputs of the UART receiver.
// The master side drives the line and the enable; the slave side is the receiver.
interface uart_rx_if;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rxbusy;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_ferr;
  logic       uart_rx_perr;

  modport master (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rxbusy,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_ferr,
    input  uart_rx_perr
  );

  modport slave (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rxbusy,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_ferr,
    output uart_rx_perr
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx - 8-bit LSB-first asynchronous serial receiver, sampling each bit at mid-bit.
// Frame is 8N1 by default; defining UART_RX_PARITY_EN adds an even parity bit (8E1)
// and enables the parity-error strobe.
// Requires CPB = CLK_FREQ / BAUD_RATE >= 4.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave rx
);
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Input path: two synchronizer stages plus one delayed copy for edge detection.
  logic sync1_q;
  logic rxs_q;
  logic rxs_dly_q;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          busy_q;
  logic          valid_q;
  logic          ferr_q;
`ifdef UART_RX_PARITY_EN
  logic          perr_q;
  logic          perr_flag_q;
`endif

  logic [CW-1:0] wait_last;
  logic          tick;
  logic          fall;

  // Synchronize the asynchronous line; all flops idle high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
    end else begin
      sync1_q   <= rx.uart_rxd;
      rxs_q     <= sync1_q;
      rxs_dly_q <= rxs_q;
    end
  end

  // Sample point of the current state: half a bit into START, a full bit elsewhere.
  always_comb begin
    wait_last = (state_q == S_START) ? CW'(HALF - 1) : CW'(CPB - 1);
    tick      = (cnt_q == wait_last);
    fall      = rxs_dly_q & ~rxs_q;
  end

  // Receiver FSM with registered busy, data and one-cycle result strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      perr_flag_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (rx.uart_rx_en && fall) begin
            state_q     <= S_START;
            busy_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_flag_q <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (tick) begin
            cnt_q <= '0;
            if (rxs_q) begin
              // Line back high at mid start bit: treat as a glitch.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt_q   <= '0;
            shift_q <= {rxs_q, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            cnt_q       <= '0;
            perr_flag_q <= (^shift_q) ^ rxs_q;
            state_q     <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (!rxs_q) begin
              ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (perr_flag_q) begin
              perr_q <= 1'b1;
`endif
            end else begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx.uart_rxbusy   = busy_q;
  assign rx.uart_rx_valid = valid_q;
  assign rx.uart_rx_data  = data_q;
  assign rx.uart_rx_ferr  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx.uart_rx_perr  = perr_q;
`else
  assign rx.uart_rx_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - randomized and directed bench for uart_rx with a frame-level reference model.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int CPB       = 10;
  localparam int HALF      = 5;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS     = 11;
  localparam bit PAR       = 1'b1;
  localparam int STOP_OFS  = HALF + 10 * CPB;
`else
  localparam int NBITS     = 10;
  localparam bit PAR       = 1'b0;
  localparam int STOP_OFS  = HALF + 9 * CPB;
`endif
  // Cycles from the first cycle busy is high to the first cycle a strobe is high.
  localparam int LAT       = STOP_OFS;
  localparam int MAXN      = 16384;

  logic clk = 1'b0;
  logic reset;
  uart_rx_if rif();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rif.slave)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int fail_shown = 0;

  typedef struct {
    int         kind;   // 0 valid, 1 ferr, 2 perr
    logic [7:0] data;
    int         lat;
  } ev_t;
  ev_t ev_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (fail_shown < 40) begin
        fail_shown++;
        $display("FAIL %s t=%0t got=%0h required=%0h", name, $time, got, exp);
      end
    end
  endtask

  // ---------------- reference model ----------------
  bit line_at [MAXN];
  bit rst_at  [MAXN];
  int n = 0;

  // Value of the synchronized line as seen by the receiver just before edge m.
  function automatic bit rxs_before(input int m);
    if (m < 2) return 1'b1;
    if (rst_at[m-1] || rst_at[m-2]) return 1'b1;
    return line_at[m-2];
  endfunction

  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = '0;
  bit         m_perr = 1'b0;
  bit         e_busy = 1'b0, e_valid = 1'b0, e_ferr = 1'b0, e_perr = 1'b0;
  logic [7:0] e_data = '0;
  bit         prev_busy = 1'b0;
  int         busy_rise = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (n >= MAXN) begin
        failures++;
        $display("FAIL watchdog cycle budget exhausted at cycle %0d", n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "cycle budget exhausted");
      end
      line_at[n] = rif.uart_rxd;
      rst_at[n]  = reset;
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      e_perr  = 1'b0;
      if (reset) begin
        m_active = 1'b0;
        e_busy   = 1'b0;
        e_data   = '0;
      end else if (!m_active) begin
        if (rif.uart_rx_en && rxs_before(n - 1) && !rxs_before(n)) begin
          m_active = 1'b1;
          m_k      = n;
          m_perr   = 1'b0;
          e_busy   = 1'b1;
        end
      end else begin
        int j;
        bit rv;
        j  = n - m_k;
        rv = rxs_before(n);
        if (j == HALF && rv) begin
          m_active = 1'b0;
          e_busy   = 1'b0;
        end else if (j > HALF && j <= HALF + 8 * CPB && ((j - HALF) % CPB) == 0) begin
          m_byte[(j - HALF) / CPB - 1] = rv;
        end else if (PAR && j == HALF + 9 * CPB) begin
          m_perr = (^m_byte) ^ rv;
        end else if (j == STOP_OFS) begin
          m_active = 1'b0;
          e_busy   = 1'b0;
          if (!rv) e_ferr = 1'b1;
          else if (PAR && m_perr) e_perr = 1'b1;
          else begin
            e_valid = 1'b1;
            e_data  = m_byte;
          end
        end
      end
      n++;

      @(negedge clk);
      check("busy",  32'(rif.uart_rxbusy),   32'(e_busy));
      check("valid", 32'(rif.uart_rx_valid), 32'(e_valid));
      check("ferr",  32'(rif.uart_rx_ferr),  32'(e_ferr));
      check("perr",  32'(rif.uart_rx_perr),  32'(e_perr));
      check("data",  32'(rif.uart_rx_data),  32'(e_data));

      // Log DUT strobes for the directed checks.
      if (rif.uart_rxbusy && !prev_busy) busy_rise = n;
      prev_busy = rif.uart_rxbusy;
      if (rif.uart_rx_valid || rif.uart_rx_ferr || rif.uart_rx_perr) begin
        ev_t e;
        e.kind = rif.uart_rx_valid ? 0 : (rif.uart_rx_ferr ? 1 : 2);
        e.data = rif.uart_rx_data;
        e.lat  = n - busy_rise;
        ev_q.push_back(e);
        $display("rx %s data=%02h lat=%0d cycle=%0d",
                 e.kind == 0 ? "valid" : (e.kind == 1 ? "ferr" : "perr"), e.data, e.lat, n);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic par_of(input logic [7:0] b);
    return ^b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int cycles);
    rif.uart_rxd = v;
    repeat (cycles) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_b, input logic stop_b,
                            input bit drop_en);
    logic [10:0] fr;
`ifdef UART_RX_PARITY_EN
    fr = {stop_b, par_b, b, 1'b0};
`else
    fr = {par_b, stop_b, b, 1'b0};  // top slot is never transmitted in 8N1
`endif
    for (int i = 0; i < NBITS; i++) begin
      hold(fr[i], CPB);
      if (i == 0 && drop_en) rif.uart_rx_en = 1'b0;
    end
    rif.uart_rxd = 1'b1;
  endtask

  task automatic expect_event(input string name, input int kind, input logic [7:0] d,
                              input int lat);
    ev_t e;
    if (ev_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s no strobe seen, required kind=%0d data=%02h", name, kind, d);
      return;
    end
    e = ev_q.pop_front();
    check({name, "_kind"}, 32'(e.kind), 32'(kind));
    if (kind == 0) check({name, "_data"}, 32'(e.data), 32'(d));
    if (lat >= 0) check({name, "_lat"}, 32'(e.lat), 32'(lat));
  endtask

  task automatic expect_none(input string name);
    checks++;
    if (ev_q.size() != 0) begin
      failures++;
      $display("FAIL %s unexpected strobes got=%0d required=0", name, ev_q.size());
    end
    ev_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       pb;
    logic       sb;
    reset = 1'b1;
    rif.uart_rxd   = 1'b1;
    rif.uart_rx_en = 1'b1;
    repeat (3) tick();
    check("rst_busy",  32'(rif.uart_rxbusy),   32'd0);
    check("rst_valid", 32'(rif.uart_rx_valid), 32'd0);
    check("rst_ferr",  32'(rif.uart_rx_ferr),  32'd0);
    check("rst_perr",  32'(rif.uart_rx_perr),  32'd0);
    check("rst_data",  32'(rif.uart_rx_data),  32'h00);
    reset = 1'b0;
    hold(1'b1, 20);

    // Reset during DATA: start bit plus bits 0,0,1 of 0x3C, then reset.
    hold(1'b0, 3 * CPB);
    hold(1'b1, CPB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy",  32'(rif.uart_rxbusy),   32'd0);
    check("midrst_valid", 32'(rif.uart_rx_valid), 32'd0);
    hold(1'b1, 20);
    expect_none("midrst_nostrobe");
    send_frame(8'h3C, par_of(8'h3C), 1'b1, 1'b0);
    hold(1'b1, 20);
    expect_event("after_rst_3c", 0, 8'h3C, LAT);

    // Good frame then a back-to-back frame.
    send_frame(8'hA5, par_of(8'hA5), 1'b1, 1'b0);
    send_frame(8'h0F, par_of(8'h0F), 1'b1, 1'b0);
    hold(1'b1, 20);
    expect_event("frame_a5", 0, 8'hA5, LAT);
    expect_event("frame_0f", 0, 8'h0F, LAT);

    // Glitch: 3 low cycles aborts at the half-bit sample.
    hold(1'b0, 3);
    hold(1'b1, 30);
    expect_none("glitch");
    check("glitch_busy", 32'(rif.uart_rxbusy), 32'd0);

    // Framing error followed by a break.
    send_frame(8'h55, par_of(8'h55), 1'b0, 1'b0);
    hold(1'b0, 30 * CPB);
    check("break_busy", 32'(rif.uart_rxbusy), 32'd0);
    expect_event("ferr_55", 1, 8'h00, -1);
    expect_none("break_no_retrigger");
    check("ferr_data_held", 32'(rif.uart_rx_data), 32'h0F);
    hold(1'b1, 30);
    expect_none("break_release");
    send_frame(8'hC3, par_of(8'hC3), 1'b1, 1'b0);
    hold(1'b1, 20);
    expect_event("after_break_c3", 0, 8'hC3, LAT);

    // Enable low during the start edge, then enable dropped mid-frame.
    rif.uart_rx_en = 1'b0;
    send_frame(8'h12, par_of(8'h12), 1'b1, 1'b0);
    hold(1'b1, 20);
    rif.uart_rx_en = 1'b1;
    hold(1'b1, 10);
    expect_none("en_low_ignored");
    send_frame(8'h81, par_of(8'h81), 1'b1, 1'b1);
    hold(1'b1, 20);
    rif.uart_rx_en = 1'b1;
    expect_event("en_drop_81", 0, 8'h81, LAT);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1.
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 20);
    expect_event("par_ok_07", 0, 8'h07, 105);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    hold(1'b1, 20);
    expect_event("par_bad_07", 2, 8'h00, 105);
    check("perr_data_held", 32'(rif.uart_rx_data), 32'h07);
`endif

    // Randomized traffic: good frames, bad stop/parity, disabled starts, glitches, zero gaps.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        hold(1'b0, $urandom_range(1, 4));
        hold(1'b1, 12);
      end else begin
        b  = 8'($urandom);
        pb = par_of(b);
        if ($urandom_range(0, 5) == 0) pb = ~pb;
        sb = ($urandom_range(0, 7) != 0);
        rif.uart_rx_en = ($urandom_range(0, 5) != 0);
        send_frame(b, pb, sb, 1'b0);
        hold(1'b1, $urandom_range(0, 15));
        rif.uart_rx_en = 1'b1;
      end
    end
    hold(1'b1, 250);
    ev_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
